// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backing memory port between instruction-side
// line refills and data-side line reads / word writes, with a fixed read latency.
module mem_port_arbiter #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [63:0] mem_read_data,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        owner, owner_nxt;          // 1 = data side
  logic        last_served, last_nxt;     // 1 = data side
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        capture;
  logic        grant_d;
  logic        grant_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      owner       <= 1'b0;
      last_served <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      i_rdata     <= 64'h0;
      d_rdata     <= 64'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      owner       <= owner_nxt;
      last_served <= last_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      if (capture) begin
        if (owner) d_rdata <= mem_read_data;
        else       i_rdata <= mem_read_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    last_nxt  = last_served;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    capture   = 1'b0;
    // Data side wins a tie unless it was the side served last.
    grant_d   = d_req && (!i_req || !last_served);
    grant_we  = grant_d && d_we;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          owner_nxt = grant_d;
          last_nxt  = grant_d;
          addr_nxt  = grant_d ? d_addr : i_addr;
          wdata_nxt = d_wdata;
          state_nxt = grant_we ? WRITE : READ;
          cnt_nxt   = grant_we ? 4'd0 : LAT_M1;
        end
      end
      READ: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign mem_write      = (state == WRITE);
  assign mem_address    = busy ? addr_q : 32'h0;
  assign mem_write_data = wdata_q;
  assign i_done         = (state == DONE) && !owner;
  assign d_done         = (state == DONE) && owner;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single backing data memory port between the instruction-side refill requester and the L1 data-cache requester. It accepts line reads (64-bit) from both sides and word writes from the data side. Each access is sequenced through a fixed read-latency counter that models the memory's address-to-data delay. Ties are resolved round-robin, and completion is signalled to the owning side with a one-cycle done pulse.

## Interface
- LAT, 3: read latency in clock cycles from grant to data capture; legal range 1..15 (4-bit counter)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- i_req  input  1  instruction-side read request, level, held until i_done
- i_addr  input  32  instruction-side byte address (line = addr[31:3])
- i_done  output  1  one-cycle completion pulse to instruction side
- i_rdata  output  64  line returned to instruction side, valid while i_done=1
- d_req  input  1  data-side request, level, held until d_done
- d_we  input  1  1 = word write, 0 = line read; sampled at grant
- d_addr  input  32  data-side byte address
- d_wdata  input  32  write word, sampled at grant
- d_done  output  1  one-cycle completion pulse to data side
- d_rdata  output  64  line returned to data side, valid while d_done=1
- mem_write  output  1  write strobe to backing memory
- mem_address  output  32  address to backing memory
- mem_write_data  output  32  write word to backing memory
- mem_read_data  input  64  line from backing memory: {word0, word1}
- busy  output  1  1 in any state other than IDLE

## Operation
- States: IDLE, READ, WRITE, DONE. State, counter, owner, latched address, latched wdata, rdata and last-served are registers.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that side.
  - Both requests: grant the side not in last_served.
  - At grant: latch owner, the owner's address, d_we (forced to 0 for instruction side) and d_wdata. Set last_served to owner.
  - Next state is WRITE if the latched we is 1; otherwise READ with cnt = LAT-1.
- READ: while cnt != 0, decrement. At the edge where cnt == 0, capture mem_read_data into the owner's rdata register and go to DONE.
- WRITE: mem_write = 1 for exactly this cycle. The backing memory commits at the closing edge. Next state is DONE.
- DONE:
  - Owner's done = 1 for exactly one cycle; the other side's done = 0.
  - Always return to IDLE.
  - The requester drops req at the edge where it samples done=1, so IDLE never re-grants a completed request.
- Output decode:
  - mem_address = latched address in READ/WRITE/DONE, 32'h0 in IDLE.
  - mem_write_data = latched wdata.
  - i_rdata/d_rdata hold their last captured value; they change only at capture.
- Addresses pass through unmodified. The backing memory selects the line and word; the arbiter does no alignment checks.
- Instruction side never writes. d_we is ignored unless the data side is granted.
- req deasserted mid-transaction: ignored. The transaction completes and done still pulses.
- Requests arriving while busy wait in IDLE for arbitration; no queueing beyond the held req level.

## Timing
- Reset values:
  - state IDLE, cnt 0, owner I, last_served I (data side wins the first tie)
  - i_done 0, d_done 0, i_rdata 0, d_rdata 0
  - mem_write 0, mem_address 0, mem_write_data 0, busy 0
- Reset mid-transaction: the transaction is abandoned with no done pulse. A write in progress is dropped, since mem_write is 0 from the cycle after the reset edge.
- Read latency: req sampled at grant edge E0. Capture occurs at edge E_LAT. done is high in the cycle between E_LAT and E_LAT+1. Total is LAT+1 edges from grant to done deassertion; LAT=1 gives done in the cycle after E1.
- Write latency: grant at E0, WRITE cycle E0..E1, done high E1..E2.
- Back-to-back: the earliest next grant is at the edge closing the IDLE cycle that follows DONE. Minimum per-access occupancy is LAT+2 cycles for a read and 3 cycles for a write.
- Only registered state drives the outputs, with no combinational paths from req to done.

## Test plan
- Reset then single i_req, i_addr=32'h0000_0040, LAT=3, memory line {32'h11111111, 32'h22222222} -> i_done high exactly one cycle, 4 edges after the grant edge, with i_rdata=64'h11111111_22222222; d_done stays 0.
- Data write: d_req, d_we=1, d_addr=32'h0000_0104, d_wdata=32'hDEADBEEF -> mem_write=1 for one cycle with mem_address=32'h104, and d_done in the following cycle. A subsequent data read of 32'h100 returns the line with word1=32'hDEADBEEF.
- i_req and d_req rising together after reset -> data side served first. The instruction side is granted next, and i_done follows d_done by LAT+2 cycles.
- Both sides held continuously for 6 accesses -> grants strictly alternate D,I,D,I,D,I.
- Assert reset in the second READ cycle of an i_req -> no i_done, all outputs at reset values. The request re-served from IDLE completes normally.
- Sweep LAT=1 and LAT=15 -> done-to-grant distances of 2 and 16 edges; d_req deasserted mid-READ still yields one d_done pulse.
